// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFun codes, arbiter FSM state encoding and the
// legal-code check used by the ALU, the shared-ALU arbiter and the benches.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_A   = 6'b011010;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_NEQ = 6'b110001;
  localparam logic [5:0] FUN_LT  = 6'b110101;
  localparam logic [5:0] FUN_LEZ = 6'b111101;
  localparam logic [5:0] FUN_GEZ = 6'b111001;
  localparam logic [5:0] FUN_GTZ = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic alu_fun_legal(input logic [5:0] fun);
    logic legal;
    case (fun)
      FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR, FUN_A,
      FUN_SLL, FUN_SRL, FUN_SRA,
      FUN_EQ, FUN_NEQ, FUN_LT, FUN_LEZ, FUN_GEZ, FUN_GTZ: legal = 1'b1;
      default:                                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational ALU. Shifts move B by A[4:0]; LEZ/GEZ/GTZ always treat A as
// signed, Sign only selects signed vs unsigned for LT. Unknown codes give 0.
module alu_share_arb_alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [5:0]   ALUFun,
  input  logic         Sign,
  output logic [W-1:0] result
);

  logic lt;
  logic a_zero;
  logic a_neg;

  always_comb begin
    lt     = Sign ? ($signed(A) < $signed(B)) : (A < B);
    a_zero = (A == '0);
    a_neg  = A[W-1];
  end

  always_comb begin
    result = '0;
    case (ALUFun)
      FUN_ADD: result = A + B;
      FUN_SUB: result = A - B;
      FUN_AND: result = A & B;
      FUN_OR:  result = A | B;
      FUN_XOR: result = A ^ B;
      FUN_NOR: result = ~(A | B);
      FUN_A:   result = A;
      FUN_SLL: result = B << A[4:0];
      FUN_SRL: result = B >> A[4:0];
      FUN_SRA: result = $signed(B) >>> A[4:0];
      FUN_EQ:  result = {{(W-1){1'b0}}, (A == B)};
      FUN_NEQ: result = {{(W-1){1'b0}}, (A != B)};
      FUN_LT:  result = {{(W-1){1'b0}}, lt};
      FUN_LEZ: result = {{(W-1){1'b0}}, (a_neg | a_zero)};
      FUN_GEZ: result = {{(W-1){1'b0}}, ~a_neg};
      FUN_GTZ: result = {{(W-1){1'b0}}, (~a_neg & ~a_zero)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one ALU through a round-robin arbiter and a
// three-state IDLE/EXEC/RESP sequencer with a held response register.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NONE_FIXED_W = 32,
  parameter bit CHECK_FUN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [NONE_FIXED_W-1:0] req0_A,
  input  logic [NONE_FIXED_W-1:0] req0_B,
  input  logic [5:0]              req0_ALUFun,
  input  logic                    req0_Sign,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [NONE_FIXED_W-1:0] req1_A,
  input  logic [NONE_FIXED_W-1:0] req1_B,
  input  logic [5:0]              req1_ALUFun,
  input  logic                    req1_Sign,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [NONE_FIXED_W-1:0] rsp_result,
  output logic                    rsp_id,
  output logic                    rsp_err,
  output arb_state_t              dbg_state
);

  if (NONE_FIXED_W != 32) begin : g_width_check
    $error("alu_share_arb supports only NONE_FIXED_W = 32");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Requesters may drop valid before ready; the response holds all rsp_*
  // fields stable from rsp_valid rising until the rsp_valid && rsp_ready edge.

  arb_state_t              state;
  logic                    last_grant;
  logic                    grant0;
  logic                    grant1;
  logic [NONE_FIXED_W-1:0] op_a;
  logic [NONE_FIXED_W-1:0] op_b;
  logic [5:0]              op_fun;
  logic                    op_sign;
  logic                    op_id;
  logic [NONE_FIXED_W-1:0] alu_result;
  logic                    fun_err;

  // last_grant=1 means requester 1 won last, so requester 0 wins a tie next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign dbg_state  = state;
  assign fun_err    = CHECK_FUN && !alu_fun_legal(op_fun);

  alu_share_arb_alu #(
    .W(NONE_FIXED_W)
  ) u_alu (
    .A      (op_a),
    .B      (op_b),
    .ALUFun (op_fun),
    .Sign   (op_sign),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_fun     <= '0;
      op_sign    <= 1'b0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            op_a       <= grant1 ? req1_A      : req0_A;
            op_b       <= grant1 ? req1_B      : req0_B;
            op_fun     <= grant1 ? req1_ALUFun : req0_ALUFun;
            op_sign    <= grant1 ? req1_Sign   : req0_Sign;
            op_id      <= grant1;
            last_grant <= grant1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_err    <= fun_err;
          rsp_result <= fun_err ? '0 : alu_result;
          rsp_id     <= op_id;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
